// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and encodings for the load/store sequencer.
// Holds the FSM state enum, the RV32I load/store funct3 encodings and
// small decode helpers used by lsu_mem_ctrl.
package lsu_pkg;

  // Sequencer states; also driven onto the controller's debug port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal funct3 detection. Loads reject 011/110/111. Stores reject any
  // encoding with bit2 set, and also 011 (the RV64 sd encoding), since no
  // store width exists for it in RV32I.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    logic bad;
    if (is_store) begin
      bad = f3[2] | (f3[1:0] == 2'b11);
    end else begin
      bad = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
    end
    return bad;
  endfunction

  // Natural-alignment check: halves need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_align: purely combinational data alignment for the load/store unit.
// Loads: selects the byte/half addressed by addr_lo out of the memory word and
// sign- or zero-extends it. Stores: merges the low byte/half of wdata into the
// memory word at addr_lo (read-modify-write data for sb/sh); sw passes wdata.
// Half accesses look at addr_lo[1] only and word accesses ignore addr_lo, so
// misaligned addresses (when not trapped) simply round down.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half out of the memory word.
  always_comb begin
    byte_sel = word[7:0];
    case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane according to the load type.
  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase
  end

  // Merge the store lane into the existing word.
  always_comb begin
    store_word = wdata;
    case (funct3[1:0])
      2'b00: begin
        store_word = word;
        case (addr_lo)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word[7:0] = wdata[7:0];
        endcase
      end
      2'b01: begin
        store_word = word;
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the core memory stage and a
// word-addressed, combinational-read data memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses fault instead of rounding the address down.
//
// Handshake: a request is taken on a posedge where req_valid && req_ready;
// req_ready is high only in IDLE, all req_* fields are captured on that edge
// and ignored otherwise. The response is a single-cycle resp_valid pulse with
// resp_rdata/resp_fault meaningful only while resp_valid is high. There is no
// backpressure on the response side.
//
// Flow: IDLE -accept-> ACCESS -> (sb/sh only) WRITE -> RESP -> IDLE.
// dbg_state exposes the current FSM state.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH = 200,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic [31:0]      resp_rdata,
  output logic             resp_fault,
  output logic [IDX_W-1:0] mem_addr,
  output logic             mem_write_enable,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output state_t           dbg_state
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state_q, state_d;

  // Request fields captured at accept.
  logic        lat_write;
  logic [2:0]  lat_f3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Datapath registers.
  logic [31:0] merged_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  // Alignment network outputs.
  logic [31:0] load_data;
  logic [31:0] store_word;

  logic        accept;
  logic        idx_oor;
  logic        bad_f3;
  logic        misaligned;
  logic        fault;

  assign accept    = req_valid && req_ready;
  assign mem_addr  = lat_addr[IDX_W+1:2];
  assign dbg_state = state_q;

  lsu_align u_align (
    .word       (mem_read_data),
    .addr_lo    (lat_addr[1:0]),
    .funct3     (lat_f3),
    .wdata      (lat_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Fault detection on the latched request. The range check uses the full
  // word index so high address bits beyond IDX_W cannot alias into memory.
  always_comb begin
    idx_oor = ({2'b00, lat_addr[31:2]} >= DEPTH_W);
    bad_f3  = f3_illegal(lat_write, lat_f3);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = is_misaligned(lat_f3, lat_addr[1:0]);
`else
    misaligned = 1'b0;
`endif
    fault = idx_oor | bad_f3 | misaligned;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and Moore/Mealy outputs; reset masks write strobe and response.
  always_comb begin
    state_d          = state_q;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_data   = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ACCESS;
      end
      ACCESS: begin
        if (fault || !lat_write) begin
          state_d = RESP;
        end else if (lat_f3 == F3_W) begin
          mem_write_enable = 1'b1;
          mem_write_data   = lat_wdata;
          state_d          = RESP;
        end else begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_data   = merged_q;
        state_d          = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      mem_write_enable = 1'b0;
      mem_write_data   = 32'h0;
      resp_valid       = 1'b0;
    end
  end

  // Request capture and datapath registers; results are produced in ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write <= 1'b0;
      lat_f3    <= 3'b000;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      merged_q  <= 32'h0;
      rdata_q   <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (state_q == ACCESS) begin
        merged_q <= store_word;
        fault_q  <= fault;
        rdata_q  <= (fault || lat_write) ? 32'h0 : load_data;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed scoreboard bench for lsu_mem_ctrl.
// The driver pushes the hand-computed {fault, rdata}, accept cycle and
// expected latency per request; a negedge monitor pops and compares on every
// resp_valid. Memory-side effects are checked against a behavioural memory.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  localparam int DEPTH = 200;
  localparam int IDX_W = 8;
  localparam int W     = 33;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic [31:0]      resp_rdata;
  logic             resp_fault;
  logic [IDX_W-1:0] mem_addr;
  logic             mem_write_enable;
  logic [31:0]      mem_write_data;
  logic [31:0]      mem_read_data;
  state_t           dbg_state;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .dbg_state        (dbg_state)
  );

  // ---------------- behavioural data memory ----------------
  logic [31:0] mem [0:255];
  logic        preload;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[3]   <= 32'h8899AABB;
      mem[5]   <= 32'h11223344;
      mem[199] <= 32'h0BADF00D;
    end else if (mem_write_enable) begin
      mem[mem_addr] <= mem_write_data;
    end
  end
  assign mem_read_data = mem[mem_addr];

  int cyc    = 0;
  int wr_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_write_enable) wr_cnt <= wr_cnt + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           lat_q[$];
  string        name_q[$];

  logic [W-1:0] m_exp;
  int           m_acc;
  int           m_lat;
  string        m_name;

  // Scoreboard monitor: compares every response against the queue head.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        m_exp  = exp_q.pop_front();
        m_acc  = acc_q.pop_front();
        m_lat  = lat_q.pop_front();
        m_name = name_q.pop_front();
        check({m_name, "_rdata"}, resp_rdata, m_exp[31:0]);
        check({m_name, "_fault"}, {31'h0, resp_fault}, {31'h0, m_exp[32]});
        check({m_name, "_latency"}, 32'(cyc - m_acc), 32'(m_lat));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input string nm, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
    int guard = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check({nm, "_accept_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_f, exp_rd});
    acc_q.push_back(cyc);
    lat_q.push_back(exp_lat);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Stream table: four loads issued with req_valid held high.
  logic [2:0]  s_f3   [4];
  logic [31:0] s_addr [4];
  logic [31:0] s_exp  [4];
  int          s_acc  [4];

  int          w0;
  logic [31:0] saved;

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b1;
    preload    = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;

    s_f3[0] = F3_W;  s_addr[0] = 32'h0C; s_exp[0] = 32'h8899AABB;
    s_f3[1] = F3_W;  s_addr[1] = 32'h14; s_exp[1] = 32'hCAFEEF44;
    s_f3[2] = F3_B;  s_addr[2] = 32'h0C; s_exp[2] = 32'hFFFFFFBB;
    s_f3[3] = F3_HU; s_addr[3] = 32'h16; s_exp[3] = 32'h0000CAFE;

    repeat (3) @(posedge clk);
    #1 preload = 1'b0;

    // Reset values (reset still asserted)
    @(negedge clk);
    check("rst_req_ready",  {31'h0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'd0);
    check("rst_mem_we",     {31'h0, mem_write_enable}, 32'd0);
    check("rst_mem_addr",   {24'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata",  mem_write_data, 32'h0);
    check("rst_state",      {30'h0, dbg_state}, {30'h0, IDLE});
    @(posedge clk);
    #1 reset = 1'b0;

    // Loads with extension
    issue("lw_0c",  1'b0, F3_W,  32'h0C, 32'h0, 32'h8899AABB, 1'b0, 2); drain();
    issue("lb_0f",  1'b0, F3_B,  32'h0F, 32'h0, 32'hFFFFFF88, 1'b0, 2); drain();
    issue("lbu_0f", 1'b0, F3_BU, 32'h0F, 32'h0, 32'h00000088, 1'b0, 2); drain();
    issue("lh_0e",  1'b0, F3_H,  32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 2); drain();
    issue("lhu_0c", 1'b0, F3_HU, 32'h0C, 32'h0, 32'h0000AABB, 1'b0, 2); drain();
    issue("lw_last_idx", 1'b0, F3_W, 32'h31C, 32'h0, 32'h0BADF00D, 1'b0, 2); drain();

    // Read-modify-write stores
    w0 = wr_cnt;
    issue("sb_15", 1'b1, F3_B, 32'h15, 32'hDEADBEEF, 32'h0, 1'b0, 3); drain();
    check("sb_15_write_pulses", 32'(wr_cnt - w0), 32'd1);
    check("sb_15_mem5", mem[5], 32'h1122EF44);
    w0 = wr_cnt;
    issue("sh_16", 1'b1, F3_H, 32'h16, 32'h0000CAFE, 32'h0, 1'b0, 3); drain();
    check("sh_16_write_pulses", 32'(wr_cnt - w0), 32'd1);
    check("sh_16_mem5", mem[5], 32'hCAFEEF44);

    // Faults
    w0 = wr_cnt;
    issue("lw_oor", 1'b0, F3_W, 32'h320, 32'h0, 32'h0, 1'b1, 2); drain();
    check("lw_oor_no_write", 32'(wr_cnt - w0), 32'd0);
    w0 = wr_cnt;
    issue("st_f3_100", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 2); drain();
    check("st_f3_100_no_write", 32'(wr_cnt - w0), 32'd0);
    check("st_f3_100_mem4", mem[4], 32'h0);
    w0 = wr_cnt;
    issue("sw_oor", 1'b1, F3_W, 32'h400, 32'h12345678, 32'h0, 1'b1, 2); drain();
    check("sw_oor_no_write", 32'(wr_cnt - w0), 32'd0);

    // Misaligned accesses
    w0 = wr_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
    issue("sw_22", 1'b1, F3_W, 32'h22, 32'h13572468, 32'h0, 1'b1, 2); drain();
    check("sw_22_no_write", 32'(wr_cnt - w0), 32'd0);
    check("sw_22_mem8", mem[8], 32'h0);
    issue("lh_0f_mis", 1'b0, F3_H, 32'h0F, 32'h0, 32'h0, 1'b1, 2); drain();
`else
    issue("sw_22", 1'b1, F3_W, 32'h22, 32'h13572468, 32'h0, 1'b0, 2); drain();
    check("sw_22_write_pulses", 32'(wr_cnt - w0), 32'd1);
    check("sw_22_mem8", mem[8], 32'h13572468);
    issue("lh_0f_mis", 1'b0, F3_H, 32'h0F, 32'h0, 32'hFFFF8899, 1'b0, 2); drain();
`endif

    // Reset in the WRITE cycle of an sb: no write, no response.
    w0    = wr_cnt;
    saved = mem[5];
    @(negedge clk);
    check("rstw_ready_before", {31'h0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h14;
    req_wdata  = 32'h000000AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_write = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rstw_we_masked",    {31'h0, mem_write_enable}, 32'd0);
    check("rstw_no_resp",      {31'h0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstw_ready_after",  {31'h0, req_ready}, 32'd1);
    check("rstw_state_idle",   {30'h0, dbg_state}, {30'h0, IDLE});
    repeat (3) @(negedge clk);
    check("rstw_no_write",     32'(wr_cnt - w0), 32'd0);
    check("rstw_mem5",         mem[5], saved);

    // Back-to-back loads with req_valid held high
    for (int k = 0; k < 4; k++) begin
      int guard = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = s_f3[k];
      req_addr   = s_addr[k];
      while (!req_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      s_acc[k] = cyc;
      if (!req_ready) begin
        check("stream_accept_timeout", 32'd0, 32'd1);
      end else begin
        exp_q.push_back({1'b0, s_exp[k]});
        acc_q.push_back(cyc);
        lat_q.push_back(2);
        name_q.push_back($sformatf("stream%0d", k));
      end
      @(posedge clk);
    end
    #1 req_valid = 1'b0;
    drain();
    for (int k = 1; k < 4; k++) begin
      check($sformatf("stream_spacing%0d", k), 32'(s_acc[k] - s_acc[k-1]), 32'd3);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
